// File: rtl/vertex_stream_if.sv
// Vertex output stream: valid/ready handshake plus vertex payload.
// The master drives the payload; the slave returns out_ready.
interface vertex_stream_if #(
  parameter int AW    = 4,
  parameter int OUT_W = 12
);
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_x;
  logic signed [OUT_W-1:0] out_y;
  logic [AW-1:0]           out_body;
  logic [1:0]              out_vertex;
  logic                    out_last;

  modport master (
    output out_valid, out_x, out_y,
    output out_body, out_vertex, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_x, out_y,
    input  out_body, out_vertex, out_last,
    output out_ready
  );
endinterface

// File: rtl/vertex_stream.sv
// Frame-based vertex streamer: walks the body table and emits the
// four saturated integer corners of every live body.
module vertex_stream #(
  parameter int MAX_BODY = 16,
  parameter int COORD_W  = 19,
  parameter int FRAC     = 7,
  parameter int HALF_W   = 16,
  localparam int AW      = $clog2(MAX_BODY),
  localparam int OUT_W   = COORD_W - FRAC
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [AW:0]               body_count,
  output logic [AW-1:0]             rd_addr,
  input  logic                      rd_alive,
  input  logic signed [COORD_W-1:0] rd_pos_x,
  input  logic signed [COORD_W-1:0] rd_pos_y,
  input  logic [HALF_W-1:0]         rd_half_w,
  input  logic [HALF_W-1:0]         rd_half_h,
  vertex_stream_if.master           strm,
  output logic                      busy,
  output logic                      done,
  output logic [7:0]                frame_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_EMIT, S_DONE
  } state_t;

  localparam logic [AW:0] MAXC = (AW+1)'(MAX_BODY);
  localparam logic signed [COORD_W:0] SMAX =
    {2'b00, {(COORD_W-1){1'b1}}};
  localparam logic signed [COORD_W:0] SMIN =
    {2'b11, {(COORD_W-1){1'b0}}};

  state_t state, state_d;
  logic [AW:0]   cnt, cnt_d;
  logic [AW-1:0] idx, idx_d;
  logic [1:0]    corner, corner_d;
  logic signed [COORD_W-1:0] px, px_d, py, py_d;
  logic [HALF_W-1:0] hw, hw_d, hh, hh_d;

  logic                    valid_d, last_d;
  logic signed [OUT_W-1:0] x_d, y_d;
  logic [AW-1:0]           body_d, addr_d;
  logic [1:0]              vert_d;
  logic                    done_d;
  logic [7:0]              fcnt_d;

  logic [AW:0] clamp;
  logic [1:0]  corner_nx;
  logic        more, last_body, fin, hs;

  // Widen, add or subtract the half-extent, saturate, then floor.
  function automatic logic signed [OUT_W-1:0] corner_val(
    input logic signed [COORD_W-1:0] c,
    input logic [HALF_W-1:0]         h,
    input logic                      sub
  );
    logic signed [COORD_W:0] e, d, s;
    e = {c[COORD_W-1], c};
    d = signed'({{(COORD_W+1-HALF_W){1'b0}}, h});
    s = sub ? e - d : e + d;
    if (s > SMAX)
      s = SMAX;
    else if (s < SMIN)
      s = SMIN;
    return s[COORD_W-1:FRAC];
  endfunction

  assign clamp     = (body_count > MAXC) ? MAXC : body_count;
  assign corner_nx = corner + 2'd1;
  assign more      = ({1'b0, idx} + 1'b1) < cnt;
  assign last_body = ({1'b0, idx} == cnt - 1'b1);
  assign hs        = strm.out_valid & strm.out_ready;
  assign busy      = (state != S_IDLE);

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    idx_d    = idx;
    corner_d = corner;
    px_d     = px;
    py_d     = py;
    hw_d     = hw;
    hh_d     = hh;
    valid_d  = strm.out_valid;
    x_d      = strm.out_x;
    y_d      = strm.out_y;
    body_d   = strm.out_body;
    vert_d   = strm.out_vertex;
    last_d   = strm.out_last;
    addr_d   = rd_addr;
    done_d   = 1'b0;
    fcnt_d   = frame_cnt;
    fin      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          cnt_d = clamp;
          idx_d = '0;
          if (clamp == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            fcnt_d  = frame_cnt + 8'd1;
          end else begin
            state_d = S_FETCH;
            addr_d  = '0;
          end
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        px_d = rd_pos_x;
        py_d = rd_pos_y;
        hw_d = rd_half_w;
        hh_d = rd_half_h;
        if (rd_alive) begin
          state_d  = S_EMIT;
          corner_d = 2'd0;
          valid_d  = 1'b1;
          x_d      = corner_val(rd_pos_x, rd_half_w, 1'b1);
          y_d      = corner_val(rd_pos_y, rd_half_h, 1'b1);
          body_d   = idx;
          vert_d   = 2'd0;
          last_d   = 1'b0;
        end else begin
          fin = 1'b1;
        end
      end
      S_EMIT: begin
        if (hs) begin
          if (corner == 2'd3) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            fin     = 1'b1;
          end else begin
            // Corners 0 and 3 sit left, corners 0 and 1 sit low.
            corner_d = corner_nx;
            vert_d   = corner_nx;
            x_d = corner_val(px, hw,
              (corner_nx == 2'd0) || (corner_nx == 2'd3));
            y_d = corner_val(py, hh, !corner_nx[1]);
            last_d = (corner_nx == 2'd3) && last_body;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (fin) begin
      if (more) begin
        idx_d   = idx + 1'b1;
        addr_d  = idx + 1'b1;
        state_d = S_FETCH;
      end else begin
        state_d = S_DONE;
        done_d  = 1'b1;
        fcnt_d  = frame_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= S_IDLE;
      cnt             <= '0;
      idx             <= '0;
      corner          <= '0;
      px              <= '0;
      py              <= '0;
      hw              <= '0;
      hh              <= '0;
      strm.out_valid  <= 1'b0;
      strm.out_x      <= '0;
      strm.out_y      <= '0;
      strm.out_body   <= '0;
      strm.out_vertex <= '0;
      strm.out_last   <= 1'b0;
      rd_addr         <= '0;
      done            <= 1'b0;
      frame_cnt       <= '0;
    end else begin
      state           <= state_d;
      cnt             <= cnt_d;
      idx             <= idx_d;
      corner          <= corner_d;
      px              <= px_d;
      py              <= py_d;
      hw              <= hw_d;
      hh              <= hh_d;
      strm.out_valid  <= valid_d;
      strm.out_x      <= x_d;
      strm.out_y      <= y_d;
      strm.out_body   <= body_d;
      strm.out_vertex <= vert_d;
      strm.out_last   <= last_d;
      rd_addr         <= addr_d;
      done            <= done_d;
      frame_cnt       <= fcnt_d;
    end
  end

endmodule
